// File: rtl/spill_buffer_flushable_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : spill_buffer_flushable_pkg                                       |
// | Purpose : Shared sizing helper for the flushable spill buffer and its      |
// |           pointer sub-module.                                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package spill_buffer_flushable_pkg;

  // Pointer width for a circular buffer of the given depth. A single-entry
  // buffer still gets a 1-bit pointer so no zero-width vectors appear.
  function automatic int unsigned sbf_ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spill_buffer_flushable_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spill_buffer_flushable_ptr                                       |
// | Purpose : Wrapping pointer counter, increments modulo Depth, with a        |
// |           synchronous clear that takes priority over increment.            |
// | Ports   : clk_i  - clock                                                   |
// |           rst_ni - asynchronous active-low reset                           |
// |           clr_i  - synchronous clear to 0                                  |
// |           inc_i  - advance pointer by one (wraps Depth-1 -> 0)             |
// |           ptr_o  - current pointer value                                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module spill_buffer_flushable_ptr
  import spill_buffer_flushable_pkg::*;
#(
  parameter  int unsigned Depth    = 2,
  localparam int unsigned PtrWidth = sbf_ptr_width(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [PtrWidth-1:0] ptr_o
);

  logic [PtrWidth-1:0] ptr_q, ptr_d;

  // Explicit wrap compare so non-power-of-two depths never reach Depth.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == PtrWidth'(Depth - 1)) ? '0 : ptr_q + PtrWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/spill_buffer_flushable.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spill_buffer_flushable                                           |
// | Purpose : Depth-parametrised flushable elastic buffer. valid_o, ready_o    |
// |           and data_o come from registered state only, cutting all          |
// |           combinational paths between the two handshakes.                  |
// | Ports   : clk_i, rst_ni        - clock, async active-low reset             |
// |           flush_i              - discard all stored entries                |
// |           valid_i/ready_o/data_i - upstream handshake                      |
// |           valid_o/ready_i/data_o - downstream handshake                    |
// |           usage_o              - number of occupied entries                |
// |           dropped_valid_o      - one-cycle pulse after a flush             |
// |           dropped_cnt_o        - entries discarded by the last flush       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module spill_buffer_flushable
  import spill_buffer_flushable_pkg::*;
#(
  parameter  type         T        = logic,
  parameter  int unsigned Depth    = 2,
  parameter  bit          Bypass   = 1'b0,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  T                    data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output T                    data_o,
  output logic [CntWidth-1:0] usage_o,
  output logic                dropped_valid_o,
  output logic [CntWidth-1:0] dropped_cnt_o
);

  localparam int unsigned PtrWidth = sbf_ptr_width(Depth);

  if (Depth < 1) begin : g_depth_check
    $error("spill_buffer_flushable: Depth must be >= 1");
  end

  if (Bypass) begin : g_bypass
    // Transparent wire-through; clock, reset and flush have no effect.
    logic unused_bypass;
    assign unused_bypass   = clk_i ^ rst_ni ^ flush_i;
    assign valid_o         = valid_i;
    assign ready_o         = ready_i;
    assign data_o          = data_i;
    assign usage_o         = '0;
    assign dropped_valid_o = 1'b0;
    assign dropped_cnt_o   = '0;
  end else begin : g_buffer
    T                    mem_q [Depth];
    logic [CntWidth-1:0] count_q, count_d;
    logic                dropped_valid_q, dropped_valid_d;
    logic [CntWidth-1:0] dropped_cnt_q, dropped_cnt_d;
    logic [PtrWidth-1:0] rd_ptr, wr_ptr;
    logic                not_full, not_empty, push, pop;

    assign not_full  = (count_q != CntWidth'(Depth));
    assign not_empty = (count_q != '0);
    // Input is refused during a flush; an output transfer still completes.
    assign push      = valid_i & not_full & ~flush_i;
    assign pop       = not_empty & ready_i;

    spill_buffer_flushable_ptr #(.Depth(Depth)) u_rd_ptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (flush_i),
      .inc_i  (pop),
      .ptr_o  (rd_ptr)
    );

    spill_buffer_flushable_ptr #(.Depth(Depth)) u_wr_ptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (flush_i),
      .inc_i  (push),
      .ptr_o  (wr_ptr)
    );

    always_comb begin
      count_d = count_q;
      if (flush_i) begin
        count_d = '0;
      end else if (push && !pop) begin
        count_d = count_q + CntWidth'(1);
      end else if (!push && pop) begin
        count_d = count_q - CntWidth'(1);
      end
    end

    // A head item popped in the flush cycle was delivered, not dropped.
    always_comb begin
      dropped_valid_d = flush_i;
      dropped_cnt_d   = dropped_cnt_q;
      if (flush_i) begin
        dropped_cnt_d = count_q - CntWidth'(pop);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        count_q         <= '0;
        dropped_valid_q <= 1'b0;
        dropped_cnt_q   <= '0;
      end else begin
        count_q         <= count_d;
        dropped_valid_q <= dropped_valid_d;
        dropped_cnt_q   <= dropped_cnt_d;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(Depth); i++) begin
          mem_q[i] <= '0;
        end
      end else if (push) begin
        mem_q[wr_ptr] <= data_i;
      end
    end

    assign ready_o         = not_full;
    assign valid_o         = not_empty;
    assign data_o          = mem_q[rd_ptr];
    assign usage_o         = count_q;
    assign dropped_valid_o = dropped_valid_q;
    assign dropped_cnt_o   = dropped_cnt_q;
  end

`ifndef SYNTHESIS
`ifndef COMMON_CELLS_ASSERTS_OFF
  // Upstream must not present data while flushing; that data is lost.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(flush_i && valid_i))
    else $warning("spill_buffer_flushable: valid_i during flush_i, input dropped");
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_spill_buffer_flushable.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_spill_buffer_flushable                                        |
// | Purpose : Scoreboard bench for spill_buffer_flushable (Depth 4, 3, 1 and   |
// |           Bypass instances).                                               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_spill_buffer_flushable;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Depth 4 instance
  logic       f4, vi4, ri4, ro4, vo4, dv4;
  logic [7:0] di4, do4;
  logic [2:0] u4, dc4;
  // Depth 3 instance
  logic       f3, vi3, ri3, ro3, vo3, dv3;
  logic [7:0] di3, do3;
  logic [1:0] u3, dc3;
  // Depth 1 instance
  logic       f1, vi1, ri1, ro1, vo1, dv1;
  logic [7:0] di1, do1;
  logic [0:0] u1, dc1;
  // Bypass instance
  logic       fb, vib, rib, rob, vob, dvb;
  logic [7:0] dib, dob;
  logic [1:0] ub, dcb;

  spill_buffer_flushable #(.T(logic [7:0]), .Depth(4), .Bypass(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f4), .valid_i(vi4), .ready_o(ro4),
    .data_i(di4), .valid_o(vo4), .ready_i(ri4), .data_o(do4), .usage_o(u4),
    .dropped_valid_o(dv4), .dropped_cnt_o(dc4));

  spill_buffer_flushable #(.T(logic [7:0]), .Depth(3), .Bypass(1'b0)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f3), .valid_i(vi3), .ready_o(ro3),
    .data_i(di3), .valid_o(vo3), .ready_i(ri3), .data_o(do3), .usage_o(u3),
    .dropped_valid_o(dv3), .dropped_cnt_o(dc3));

  spill_buffer_flushable #(.T(logic [7:0]), .Depth(1), .Bypass(1'b0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f1), .valid_i(vi1), .ready_o(ro1),
    .data_i(di1), .valid_o(vo1), .ready_i(ri1), .data_o(do1), .usage_o(u1),
    .dropped_valid_o(dv1), .dropped_cnt_o(dc1));

  spill_buffer_flushable #(.T(logic [7:0]), .Depth(2), .Bypass(1'b1)) dutb (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fb), .valid_i(vib), .ready_o(rob),
    .data_i(dib), .valid_o(vob), .ready_i(rib), .data_o(dob), .usage_o(ub),
    .dropped_valid_o(dvb), .dropped_cnt_o(dcb));

  // Scoreboards: stimulus pushes expected payloads, monitors pop on handshake.
  logic [7:0] q4[$];
  logic [7:0] q3[$];
  logic [7:0] q1[$];
  int hs1 = 0;

  always @(negedge clk) begin
    if (rst_n && vo4 && ri4) begin
      if (q4.size() == 0) chk("d4_unexpected_item", 32'(do4), 32'hFFFF_FFFF);
      else chk("d4_data", 32'(do4), 32'(q4.pop_front()));
    end
    if (rst_n && vo3 && ri3) begin
      if (q3.size() == 0) chk("d3_unexpected_item", 32'(do3), 32'hFFFF_FFFF);
      else chk("d3_data", 32'(do3), 32'(q3.pop_front()));
    end
    if (rst_n && vo1 && ri1) begin
      hs1++;
      if (q1.size() == 0) chk("d1_unexpected_item", 32'(do1), 32'hFFFF_FFFF);
      else chk("d1_data", 32'(do1), 32'(q1.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       v;
    logic       r;
    logic [7:0] d;
  } byp_vec_t;

  initial begin
    byp_vec_t bv[3];
    bv[0] = '{v: 1'b1, r: 1'b0, d: 8'hA5};
    bv[1] = '{v: 1'b0, r: 1'b1, d: 8'h3C};
    bv[2] = '{v: 1'b1, r: 1'b1, d: 8'hFF};

    {f4, vi4, ri4, di4} = '0;
    {f3, vi3, ri3, di3} = '0;
    {f1, vi1, ri1, di1} = '0;
    {fb, vib, rib, dib} = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_valid_o", 32'(vo4), 0);
    chk("rst_ready_o", 32'(ro4), 1);
    chk("rst_data_o", 32'(do4), 0);
    chk("rst_usage_o", 32'(u4), 0);
    chk("rst_dropped_valid", 32'(dv4), 0);
    chk("rst_dropped_cnt", 32'(dc4), 0);

    // 1: fill Depth 4 with ready_i low, then drain in order
    step();
    for (int i = 0; i < 4; i++) begin
      vi4 = 1'b1;
      di4 = 8'((i + 1) * 8'h11);
      q4.push_back(di4);
      step();
      chk("t1_usage_fill", 32'(u4), 32'(i + 1));
    end
    vi4 = 1'b0;
    chk("t1_ready_when_full", 32'(ro4), 0);
    ri4 = 1'b1;
    step();
    chk("t1_ready_after_pop", 32'(ro4), 1);
    chk("t1_usage_after_pop", 32'(u4), 3);
    repeat (3) step();
    chk("t1_usage_drained", 32'(u4), 0);
    chk("t1_valid_drained", 32'(vo4), 0);
    ri4 = 1'b0;

    // 2: continuous streaming on Depth 4 and Depth 3
    ri4 = 1'b1; ri3 = 1'b1; vi4 = 1'b1; vi3 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      di4 = 8'(i);
      di3 = 8'(i + 7);
      q4.push_back(di4);
      q3.push_back(di3);
      step();
      chk("t2_usage_d4", 32'(u4), 1);
      chk("t2_usage_d3", 32'(u3), 1);
    end
    vi4 = 1'b0; vi3 = 1'b0;
    step();
    chk("t2_usage_d4_end", 32'(u4), 0);
    chk("t2_usage_d3_end", 32'(u3), 0);
    chk("t2_items_left_d4", 32'(q4.size()), 0);
    chk("t2_items_left_d3", 32'(q3.size()), 0);
    ri4 = 1'b0; ri3 = 1'b0;

    // 3: flush with 3 held and ready_i high; head is delivered
    for (int i = 0; i < 3; i++) begin
      vi4 = 1'b1;
      di4 = 8'(8'hA1 + i);
      q4.push_back(di4);
      step();
    end
    vi4 = 1'b0;
    f4 = 1'b1; ri4 = 1'b1;
    step();
    f4 = 1'b0; ri4 = 1'b0;
    chk("t3_valid_after_flush", 32'(vo4), 0);
    chk("t3_usage_after_flush", 32'(u4), 0);
    chk("t3_ready_after_flush", 32'(ro4), 1);
    chk("t3_dropped_valid", 32'(dv4), 1);
    chk("t3_dropped_cnt", 32'(dc4), 2);
    q4.delete();
    step();
    chk("t3_dropped_pulse_end", 32'(dv4), 0);
    chk("t3_dropped_cnt_hold", 32'(dc4), 2);

    // 4: flush while full with ready_i low, then push right after
    for (int i = 0; i < 4; i++) begin
      vi4 = 1'b1;
      di4 = 8'(8'hB0 + i);
      q4.push_back(di4);
      step();
    end
    vi4 = 1'b0;
    f4 = 1'b1;
    step();
    f4 = 1'b0;
    chk("t4_dropped_valid", 32'(dv4), 1);
    chk("t4_dropped_cnt", 32'(dc4), 4);
    chk("t4_ready_after_flush", 32'(ro4), 1);
    q4.delete();
    vi4 = 1'b1; di4 = 8'h5A;
    q4.push_back(di4);
    step();
    vi4 = 1'b0;
    chk("t4_valid_new", 32'(vo4), 1);
    chk("t4_data_new", 32'(do4), 32'h5A);
    chk("t4_usage_new", 32'(u4), 1);
    ri4 = 1'b1;
    step();
    ri4 = 1'b0;
    chk("t4_valid_drained", 32'(vo4), 0);

    // Back-to-back flushes: held flush pulses twice with 0, then one item
    f4 = 1'b1;
    step();
    chk("bb_pulse1", 32'(dv4), 1);
    chk("bb_cnt1", 32'(dc4), 0);
    step();
    chk("bb_pulse2", 32'(dv4), 1);
    chk("bb_cnt2", 32'(dc4), 0);
    f4 = 1'b0;
    vi4 = 1'b1; di4 = 8'h77;
    step();
    vi4 = 1'b0;
    f4 = 1'b1;
    step();
    f4 = 1'b0;
    chk("bb_pulse3", 32'(dv4), 1);
    chk("bb_cnt3", 32'(dc4), 1);
    step();
    chk("bb_pulse_end", 32'(dv4), 0);

    // 5a: Depth 1 gives one transfer every other cycle
    for (int k = 0; k < 20; k += 2) q1.push_back(8'(k));
    ri1 = 1'b1; vi1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      di1 = 8'(k);
      @(negedge clk);
      chk("t5_d1_valid_phase", 32'(vo1), 32'(k % 2));
      @(posedge clk);
      #1;
    end
    vi1 = 1'b0;
    chk("t5_d1_transfers", 32'(hs1), 10);
    chk("t5_d1_items_left", 32'(q1.size()), 0);
    ri1 = 1'b0;

    // 5b: Bypass follows inputs within the cycle
    for (int i = 0; i < 3; i++) begin
      vib = bv[i].v; rib = bv[i].r; dib = bv[i].d;
      #1;
      case (i)
        0: begin
          chk("byp_valid0", 32'(vob), 1);
          chk("byp_ready0", 32'(rob), 0);
          chk("byp_data0", 32'(dob), 32'hA5);
        end
        1: begin
          chk("byp_valid1", 32'(vob), 0);
          chk("byp_ready1", 32'(rob), 1);
          chk("byp_data1", 32'(dob), 32'h3C);
        end
        default: begin
          chk("byp_valid2", 32'(vob), 1);
          chk("byp_ready2", 32'(rob), 1);
          chk("byp_data2", 32'(dob), 32'hFF);
        end
      endcase
      chk("byp_usage", 32'(ub), 0);
      chk("byp_dropped", 32'({dvb, dcb}), 0);
    end
    {vib, rib, dib} = '0;

    // 6: asynchronous reset while holding 2 items
    step();
    for (int i = 0; i < 2; i++) begin
      vi4 = 1'b1;
      di4 = 8'(8'hC1 + i);
      step();
    end
    vi4 = 1'b0;
    chk("t6_usage_before", 32'(u4), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_async", 32'(vo4), 0);
    chk("t6_usage_async", 32'(u4), 0);
    chk("t6_ready_async", 32'(ro4), 1);
    chk("t6_dropped_async", 32'(dv4), 0);
    step();
    chk("t6_dropped_in_reset", 32'(dv4), 0);
    rst_n = 1'b1;
    step();
    chk("t6_dropped_after", 32'(dv4), 0);
    chk("t6_dropped_cnt_cleared", 32'(dc4), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
